// File: rtl/spike_event_scheduler.sv
// spike_event_scheduler
// Time-ordered stimulus source for the external spike router. Timestamped
// events (time, row, synapse address) are queued in a FIFO. Each event leaves
// as a one-cycle pulse on its row lane once the free-running time counter has
// reached the event's timestamp. The due and ordering tests are wrap-aware:
// an event counts as reached when the MSB of (now - time) is clear.
module spike_event_scheduler #(
  parameter int NUM_SYNAPSE_ROWS = 2,
  parameter int ADDR_WIDTH       = 6,
  parameter int TIME_WIDTH       = 16,
  parameter int DEPTH            = 16,
  localparam int ROW_W = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   clear,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [TIME_WIDTH-1:0]                  wr_time,
  input  logic [ROW_W-1:0]                       wr_row,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  output logic [NUM_SYNAPSE_ROWS-1:0]            spike_valid,
  output logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] spike_addr,
  output logic [TIME_WIDTH-1:0]                  now,
  output logic [CNT_W-1:0]                       count,
  output logic                                   late_err,
  output logic                                   order_err,
  output logic                                   wr_err
);

  localparam int PTR_W = $clog2(DEPTH);

  // Event storage; contents are only meaningful between rd and wr pointers,
  // so the arrays carry no reset.
  logic [TIME_WIDTH-1:0] r_fifo_time [DEPTH];
  logic [ROW_W-1:0]      r_fifo_row  [DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];

  // Queue control.
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Time base and last accepted timestamp (for the ordering check).
  logic [TIME_WIDTH-1:0] r_now;
  logic [TIME_WIDTH-1:0] r_last_time;
  logic                  r_have_last;

  // Registered spike outputs.
  logic [NUM_SYNAPSE_ROWS-1:0]            r_spike_valid;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] r_spike_addr;

  // Sticky error flags.
  logic r_late_err;
  logic r_order_err;
  logic r_wr_err;

  // Combinational decisions.
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_drop;
  logic [TIME_WIDTH-1:0]       w_head_time;
  logic [ROW_W-1:0]            w_head_row;
  logic [ADDR_WIDTH-1:0]       w_head_addr;
  logic [TIME_WIDTH-1:0]       w_head_age;
  logic                        w_due;
  logic                        w_late;
  logic [TIME_WIDTH-1:0]       w_order_age;
  logic                        w_out_of_order;
  logic [NUM_SYNAPSE_ROWS-1:0] w_row_onehot;
  logic                        w_row_hit;

  // Occupancy flags come from the registered count, so a pop in the same
  // cycle never frees a slot for a write while the FIFO reads as full.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign wr_ready = ~w_full;

  assign w_head_time = r_fifo_time[r_rd_ptr];
  assign w_head_row  = r_fifo_row[r_rd_ptr];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];

  // Wrap-aware due test: the head has been reached when now - time is a
  // non-negative quantity in TIME_WIDTH-bit two's complement.
  assign w_head_age = r_now - w_head_time;
  assign w_due      = ~w_head_age[TIME_WIDTH-1];

  // Clear overrides both queue operations in its cycle.
  assign w_push = wr_valid & ~w_full & ~clear;
  assign w_pop  = enable & ~w_empty & w_due & ~clear;
  assign w_drop = wr_valid & w_full & ~clear;

  // A release is late when it happens after the exact timestamp cycle.
  // Events for a non-existent row are discarded silently.
  assign w_late = w_pop & w_row_hit & (r_now != w_head_time);

  // A new timestamp earlier than the previous accepted one (same MSB rule).
  assign w_order_age    = wr_time - r_last_time;
  assign w_out_of_order = w_push & r_have_last & w_order_age[TIME_WIDTH-1];

  // Decode the head's row into a lane mask; out-of-range rows match no lane.
  always_comb begin
    w_row_onehot = '0;
    for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
      if (w_head_row == ROW_W'(r)) begin
        w_row_onehot[r] = 1'b1;
      end
    end
  end

  assign w_row_hit = |w_row_onehot;

  // Store an accepted event at the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_time[r_wr_ptr] <= wr_time;
      r_fifo_row[r_wr_ptr]  <= wr_row;
      r_fifo_addr[r_wr_ptr] <= wr_addr;
    end
  end

  // Track the most recent accepted timestamp for the ordering check.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_last_time <= wr_time;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Time counter: advances while enabled, wraps naturally, cleared by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_now <= '0;
    end else if (clear) begin
      r_now <= '0;
    end else if (enable) begin
      r_now <= r_now + 1'b1;
    end
  end

  // Remember whether any timestamp has been accepted since reset/clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_have_last <= 1'b0;
    end else if (clear) begin
      r_have_last <= 1'b0;
    end else if (w_push) begin
      r_have_last <= 1'b1;
    end
  end

  // Released event becomes a one-cycle pulse on its lane; lane addresses hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spike_valid <= '0;
      r_spike_addr  <= '0;
    end else begin
      r_spike_valid <= '0;
      if (w_pop) begin
        r_spike_valid <= w_row_onehot;
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
          if (w_row_onehot[r]) begin
            r_spike_addr[r*ADDR_WIDTH +: ADDR_WIDTH] <= w_head_addr;
          end
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_late_err  <= 1'b0;
      r_order_err <= 1'b0;
      r_wr_err    <= 1'b0;
    end else if (clear) begin
      r_late_err  <= 1'b0;
      r_order_err <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      if (w_late) begin
        r_late_err <= 1'b1;
      end
      if (w_out_of_order) begin
        r_order_err <= 1'b1;
      end
      if (w_drop) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  assign spike_valid = r_spike_valid;
  assign spike_addr  = r_spike_addr;
  assign now         = r_now;
  assign count       = r_count;
  assign late_err    = r_late_err;
  assign order_err   = r_order_err;
  assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Bench for spike_event_scheduler: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based reference model. A second
// instance with a 4-bit time base exercises timestamp wrap-around.
module tb_spike_event_scheduler;

  logic clk = 1'b0;
  logic reset;

  // Main instance (default parameters).
  logic        enable, clear, wr_valid, wr_ready;
  logic [15:0] wr_time;
  logic        wr_row;
  logic [5:0]  wr_addr;
  logic [1:0]  spike_valid;
  logic [11:0] spike_addr;
  logic [15:0] now;
  logic [4:0]  count;
  logic        late_err, order_err, wr_err;

  // Narrow-time instance.
  logic        en2, clr2, wv2, rdy2;
  logic [3:0]  t2;
  logic        row2;
  logic [5:0]  addr2;
  logic [1:0]  sv2;
  logic [11:0] sa2;
  logic [3:0]  now2;
  logic [2:0]  cnt2;
  logic        late2, ord2, werr2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_event_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_time(wr_time),
    .wr_row(wr_row), .wr_addr(wr_addr), .spike_valid(spike_valid),
    .spike_addr(spike_addr), .now(now), .count(count),
    .late_err(late_err), .order_err(order_err), .wr_err(wr_err)
  );

  spike_event_scheduler #(.TIME_WIDTH(4), .DEPTH(4)) dut_w4 (
    .clk(clk), .reset(reset), .enable(en2), .clear(clr2),
    .wr_valid(wv2), .wr_ready(rdy2), .wr_time(t2),
    .wr_row(row2), .wr_addr(addr2), .spike_valid(sv2),
    .spike_addr(sa2), .now(now2), .count(cnt2),
    .late_err(late2), .order_err(ord2), .wr_err(werr2)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned t;
    int unsigned row;
    int unsigned addr;
  } ev_t;

  ev_t         mq[$];
  int unsigned m_now, m_last;
  bit          m_have, m_late, m_order, m_wrerr;
  logic [1:0]  m_sv;
  logic [11:0] m_addr;

  // a is strictly earlier than b on the 16-bit wrapping time line
  function automatic bit earlier(int unsigned a, int unsigned b);
    return (((a - b) & 32'hFFFF) >= 32'h8000);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_now = 0; m_last = 0; m_have = 0;
    m_late = 0; m_order = 0; m_wrerr = 0;
    m_sv = '0; m_addr = '0;
  endtask

  // Predict state after the coming clock edge from the current inputs.
  task automatic model_eval();
    bit  full;
    ev_t h;
    ev_t n;
    if (clear) begin
      mq.delete();
      m_now = 0; m_have = 0;
      m_late = 0; m_order = 0; m_wrerr = 0;
      m_sv = '0;
    end else begin
      full = (mq.size() == 16);
      m_sv = '0;
      if (wr_valid && full) m_wrerr = 1;
      if (enable && mq.size() > 0 && !earlier(m_now, mq[0].t)) begin
        h = mq.pop_front();
        m_sv[h.row] = 1'b1;
        m_addr[h.row*6 +: 6] = 6'(h.addr);
        if (m_now != h.t) m_late = 1;
      end
      if (wr_valid && !full) begin
        if (m_have && earlier(32'(wr_time), m_last)) m_order = 1;
        m_last = 32'(wr_time);
        m_have = 1;
        n.t = 32'(wr_time); n.row = 32'(wr_row); n.addr = 32'(wr_addr);
        mq.push_back(n);
      end
      if (enable) m_now = (m_now + 1) & 32'hFFFF;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("spike_valid", 32'(spike_valid), 32'(m_sv));
    check("spike_addr", 32'(spike_addr), 32'(m_addr));
    check("now", 32'(now), m_now);
    check("count", 32'(count), 32'(mq.size()));
    check("wr_ready", 32'(wr_ready), 32'(mq.size() != 16));
    check("late_err", 32'(late_err), 32'(m_late));
    check("order_err", 32'(order_err), 32'(m_order));
    check("wr_err", 32'(wr_err), 32'(m_wrerr));
  endtask

  // One clock with the inputs currently applied, then compare.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic put(input int unsigned t, input bit r, input int unsigned a);
    wr_valid = 1'b1;
    wr_time  = 16'(t);
    wr_row   = r;
    wr_addr  = 6'(a);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sv"}, 32'(spike_valid), 32'd0);
    check({tag, "_sa"}, 32'(spike_addr), 32'd0);
    check({tag, "_now"}, 32'(now), 32'd0);
    check({tag, "_cnt"}, 32'(count), 32'd0);
    check({tag, "_rdy"}, 32'(wr_ready), 32'd1);
    check({tag, "_errs"}, 32'({late_err, order_err, wr_err}), 32'd0);
  endtask

  // Assert reset between clock edges; outputs must drop without a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    enable = 0; clear = 0; wr_valid = 0; wr_time = '0; wr_row = 0; wr_addr = '0;
    en2 = 0; clr2 = 0; wv2 = 0; t2 = '0; row2 = 0; addr2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Single event T=5 on row 1, addr 3: pulse in the cycle after now==5.
    put(5, 1'b1, 3);
    check("t1_count_after_write", 32'(count), 32'd1);
    enable = 1'b1;
    repeat (5) step();
    check("t1_now5", 32'(now), 32'd5);
    check("t1_no_pulse_yet", 32'(spike_valid), 32'd0);
    step();
    check("t1_pulse", 32'(spike_valid), 32'b10);
    check("t1_lane1_addr", 32'(spike_addr[11:6]), 32'd3);
    check("t1_count_drained", 32'(count), 32'd0);
    step();
    check("t1_pulse_one_cycle", 32'(spike_valid), 32'd0);

    // Three events sharing T=10 drain on consecutive cycles.
    enable = 1'b0;
    do_clear();
    put(10, 1'b0, 0);
    put(10, 1'b1, 1);
    put(10, 1'b0, 2);
    enable = 1'b1;
    repeat (11) step();
    check("t2_first_pulse", 32'(spike_valid), 32'b01);
    check("t2_first_late", 32'(late_err), 32'd0);
    step();
    check("t2_second_pulse", 32'(spike_valid), 32'b10);
    check("t2_second_addr", 32'(spike_addr[11:6]), 32'd1);
    check("t2_late_set", 32'(late_err), 32'd1);
    step();
    check("t2_third_pulse", 32'(spike_valid), 32'b01);
    check("t2_third_addr", 32'(spike_addr[5:0]), 32'd2);

    // Fill with time frozen, then overflow.
    enable = 1'b0;
    do_clear();
    for (int i = 0; i < 16; i++) put(100 + i, 1'(i), i);
    check("t3_full_count", 32'(count), 32'd16);
    check("t3_not_ready", 32'(wr_ready), 32'd0);
    put(200, 1'b0, 9);
    check("t3_wr_err", 32'(wr_err), 32'd1);
    check("t3_count_held", 32'(count), 32'd16);

    // Out-of-order write is flagged and still released in FIFO order.
    do_clear();
    put(20, 1'b0, 7);
    put(8, 1'b1, 8);
    check("t4_order_err", 32'(order_err), 32'd1);
    enable = 1'b1;
    repeat (23) step();
    check("t4_late_err", 32'(late_err), 32'd1);
    check("t4_drained", 32'(count), 32'd0);

    // Clear while releasing: no further pulses.
    enable = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) put(3 + i, 1'(i), 10 + i);
    enable = 1'b1;
    repeat (5) step();
    do_clear();
    check("t6_clear_count", 32'(count), 32'd0);
    check("t6_clear_now", 32'(now), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t6_no_pulse", 32'(spike_valid), 32'd0);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) put(3 + i, 1'(i), 20 + i);
    enable = 1'b1;
    repeat (5) step();
    async_reset();

    // Random traffic.
    do_clear();
    for (int c = 0; c < 1500; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 299) == 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0)
        wr_time = 16'(m_now - $urandom_range(1, 20));
      else
        wr_time = 16'(m_now + $urandom_range(0, 30));
      wr_row  = 1'($urandom_range(0, 1));
      wr_addr = 6'($urandom_range(0, 63));
      step();
    end
    clear = 1'b0; wr_valid = 1'b0; enable = 1'b0;

    // Wrap-around on the 4-bit time base: T=1 written at now=14 is future.
    en2 = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("w4_now14", 32'(now2), 32'd14);
    wv2 = 1'b1; t2 = 4'd1; row2 = 1'b0; addr2 = 6'd5;
    @(posedge clk);
    #1;
    wv2 = 1'b0;
    check("w4_queued", 32'(cnt2), 32'd1);
    check("w4_no_pulse_now15", 32'(sv2), 32'd0);
    @(posedge clk);
    #1;
    check("w4_no_pulse_now0", 32'(sv2), 32'd0);
    check("w4_wrapped_now", 32'(now2), 32'd0);
    @(posedge clk);
    #1;
    check("w4_no_pulse_now1", 32'(sv2), 32'd0);
    @(posedge clk);
    #1;
    check("w4_pulse", 32'(sv2), 32'b01);
    check("w4_addr", 32'(sa2[5:0]), 32'd5);
    check("w4_drained", 32'(cnt2), 32'd0);
    check("w4_not_late", 32'(late2), 32'd0);
    @(posedge clk);
    #1;
    check("w4_pulse_ends", 32'(sv2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
